fetch_stage: RTL and testbench

//  Instruction-fetch stage of the vector ASIP pipeline. It holds the PC and drives a synchronous-read

---
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, synchronous-read imem fetch, redirect flush and stall hold; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
    parameter int N = 16,
    parameter int PC_W = 8,
    parameter logic [N-1:0] NOP = 16'hB000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [2:0]      pc_write_en,
    input  logic            flag_z,
    input  logic            flag_n,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [N-1:0]    imem_rdata,
    output logic [N-1:0]    instruction,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    output logic            branch_taken
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     perf_fetch_cnt,
    output logic [15:0]     perf_flush_cnt
`endif
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] rd_pc_q, rd_pc_d;
    logic            held_q, held_d;
    logic [N-1:0]    hold_instr_q, hold_instr_d;
    logic [PC_W-1:0] hold_pc_q, hold_pc_d;
    logic            taken, hold;
    // Redirect decision, next PC/state, and the skid copy of the word frozen by a stall
    always_comb begin
        taken = pc_write_en[2] | (pc_write_en[1] & flag_z) | (pc_write_en[0] & flag_n);
        hold = stall & ~taken;
        pc_d = taken ? jump_target : hold ? pc_q : pc_q + PC_W'(1);
        state_d = taken ? S_FLUSH : hold ? state_q : S_RUN;
        rd_pc_d = pc_q;
        held_d = hold & (state_q == S_RUN);
        hold_instr_d = held_q ? hold_instr_q : imem_rdata;
        hold_pc_d = held_q ? hold_pc_q : rd_pc_q;
    end
    // Output view: bubble outside S_RUN, frozen copy while held, else the word just read
    always_comb begin
        instr_valid = state_q == S_RUN;
        instruction = !instr_valid ? NOP : held_q ? hold_instr_q : imem_rdata;
        instr_pc = held_q ? hold_pc_q : rd_pc_q;
        imem_addr = pc_q;
        branch_taken = taken;
    end
    // Pipeline state registers; reset restarts at PC 0 in S_BOOT and drops any flush or hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q <= '0;
            rd_pc_q <= '0;
            held_q <= 1'b0;
            hold_instr_q <= NOP;
            hold_pc_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            rd_pc_q <= rd_pc_d;
            held_q <= held_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q <= hold_pc_d;
        end
    end
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_q, perf_fetch_d, perf_flush_q, perf_flush_d;
    // Saturating counts of consumed valid words and accepted redirects
    always_comb begin
        perf_fetch_d = (instr_valid & ~stall & ~&perf_fetch_q) ? perf_fetch_q + 16'd1 : perf_fetch_q;
        perf_flush_d = (taken & ~&perf_flush_q) ? perf_flush_q + 16'd1 : perf_flush_q;
        perf_fetch_cnt = perf_fetch_q;
        perf_flush_cnt = perf_flush_q;
    end
    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven bench for fetch_stage with a synchronous ROM model (ROM[i] = 16'h1000+i)
module tb_fetch_stage;
    localparam logic O = 1'b0, I = 1'b1;
    localparam logic [15:0] NOPW = 16'hB000;
    logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flag_z = 1'b0, flag_n = 1'b0;
    logic [2:0] pc_write_en = 3'b000;
    logic [7:0] jump_target = 8'h00, imem_addr, instr_pc;
    logic [15:0] imem_rdata = 16'h0000, instruction;
    logic instr_valid, branch_taken;
    logic [15:0] rom [256];
    int total = 0, bad = 0, m_fetch = 0, m_flush = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt, perf_flush_cnt;
`endif

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .pc_write_en(pc_write_en),
        .flag_z(flag_z), .flag_n(flag_n), .jump_target(jump_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .branch_taken(branch_taken)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= rom[imem_addr];

    typedef struct {
        logic st; logic [2:0] pwe; logic z; logic n; logic [7:0] tgt;
        logic [15:0] ins; logic [7:0] pc; logic v; logic [7:0] addr; logic tk;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] ins, input logic [7:0] pc, input logic v, input logic [7:0] addr);
        chk({tag, " instruction"}, int'(instruction), int'(ins));
        chk({tag, " instr_valid"}, int'(instr_valid), int'(v));
        chk({tag, " imem_addr"}, int'(imem_addr), int'(addr));
        if (v) chk({tag, " instr_pc"}, int'(instr_pc), int'(pc));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
        //           st pwe     z  n  tgt    ins       pc     v  addr   tk
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'h00, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1000, 8'h00, I, 8'h01, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1001, 8'h01, I, 8'h02, O});
        vq.push_back('{O, 3'b100, O, O, 8'h40, 16'h1002, 8'h02, I, 8'h03, I});
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'h40, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1040, 8'h40, I, 8'h41, O});
        vq.push_back('{O, 3'b010, O, O, 8'h00, 16'h1041, 8'h41, I, 8'h42, O});
        vq.push_back('{O, 3'b010, I, O, 8'h80, 16'h1042, 8'h42, I, 8'h43, I});
        vq.push_back('{O, 3'b001, I, O, 8'h00, NOPW,     8'h00, O, 8'h80, O});
        vq.push_back('{O, 3'b001, O, I, 8'h10, 16'h1080, 8'h80, I, 8'h81, I});
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'h10, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1010, 8'h10, I, 8'h11, O});
        vq.push_back('{I, 3'b000, O, O, 8'h00, 16'h1011, 8'h11, I, 8'h12, O});
        vq.push_back('{I, 3'b000, O, O, 8'h00, 16'h1011, 8'h11, I, 8'h12, O});
        vq.push_back('{I, 3'b000, O, O, 8'h00, 16'h1011, 8'h11, I, 8'h12, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1011, 8'h11, I, 8'h12, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1012, 8'h12, I, 8'h13, O});
        vq.push_back('{I, 3'b100, O, O, 8'h20, 16'h1013, 8'h13, I, 8'h14, I});
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'h20, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1020, 8'h20, I, 8'h21, O});
        vq.push_back('{O, 3'b100, O, O, 8'h30, 16'h1021, 8'h21, I, 8'h22, I});
        vq.push_back('{O, 3'b100, O, O, 8'h50, NOPW,     8'h00, O, 8'h30, I});
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'h50, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1050, 8'h50, I, 8'h51, O});
        vq.push_back('{O, 3'b100, O, O, 8'hFE, 16'h1051, 8'h51, I, 8'h52, I});
        vq.push_back('{O, 3'b000, O, O, 8'h00, NOPW,     8'h00, O, 8'hFE, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h10FE, 8'hFE, I, 8'hFF, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h10FF, 8'hFF, I, 8'h00, O});
        vq.push_back('{O, 3'b000, O, O, 8'h00, 16'h1000, 8'h00, I, 8'h01, O});

        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", NOPW, 8'h00, O, 8'h00);
        chk("reset instr_pc", int'(instr_pc), 0);
        chk("reset branch_taken", int'(branch_taken), 0);
        rst = 1'b0;
        foreach (vq[i]) begin
            stall = vq[i].st; pc_write_en = vq[i].pwe; flag_z = vq[i].z;
            flag_n = vq[i].n; jump_target = vq[i].tgt;
            #1;
            chk_out($sformatf("vec%0d", i), vq[i].ins, vq[i].pc, vq[i].v, vq[i].addr);
            chk($sformatf("vec%0d branch_taken", i), int'(branch_taken), int'(vq[i].tk));
            if (vq[i].v & ~vq[i].st) m_fetch++;
            if (vq[i].tk) m_flush++;
            @(negedge clk);
        end
        stall = 1'b0; pc_write_en = 3'b000; flag_z = 1'b0; flag_n = 1'b0;
`ifdef FETCH_PERF_CNT_EN
        #1;
        chk("perf_fetch_cnt", int'(perf_fetch_cnt), m_fetch);
        chk("perf_flush_cnt", int'(perf_flush_cnt), m_flush);
`endif
        pc_write_en = 3'b100; jump_target = 8'h60;
        #1;
        chk_out("pre-flush", 16'h1001, 8'h01, I, 8'h02);
        chk("pre-flush branch_taken", int'(branch_taken), 1);
        @(negedge clk);
        pc_write_en = 3'b000;
        #1;
        chk_out("flush", NOPW, 8'h00, O, 8'h60);
        rst = 1'b1; stall = 1'b1;
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        #1;
        chk_out("rst-in-flush", NOPW, 8'h00, O, 8'h00);
        chk("rst-in-flush instr_pc", int'(instr_pc), 0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst perf_fetch_cnt", int'(perf_fetch_cnt), 0);
        chk("rst perf_flush_cnt", int'(perf_flush_cnt), 0);
`endif
        @(negedge clk);
        #1;
        chk_out("refetch", 16'h1000, 8'h00, I, 8'h01);
        @(negedge clk);
        #1;
        chk_out("refetch2", 16'h1001, 8'h01, I, 8'h02);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
